// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for div/divu, one quotient bit per clock.
// Ports: clk, rst (async, active-high), start, is_signed, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
// Build option: define DIV_ZERO_FAST_EN to finish divide-by-zero one cycle after start.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             zero_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand magnitudes; the most-negative value maps onto itself,
    // which is its correct unsigned magnitude.
    always_comb begin
        a_neg   = is_signed & dividend[WIDTH-1];
        b_neg   = is_signed & divisor[WIDTH-1];
        dvd_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        dvs_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try subtracting; a set top bit means it went negative.
    always_comb begin
        shifted = {prem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Sign correction and zero-divisor override applied once at the end.
    always_comb begin
        q_fin = neg_q ? (~quo + WIDTH'(1)) : quo;
        r_fin = neg_r ? (~prem + WIDTH'(1)) : prem;
        if (zero_q) begin
            q_fin = '1;
            r_fin = dvd_raw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            prem        <= '0;
            quo         <= '0;
            dvs         <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_raw <= dividend;
                        dvs     <= dvs_mag;
                        quo     <= dvd_mag;
                        prem    <= '0;
                        count   <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        zero_q  <= (divisor == '0);
                        state   <= RUN;
`ifdef DIV_ZERO_FAST_EN
                        // Jump straight to the finishing step without
                        // ever raising busy.
                        if (divisor == '0) begin
                            count <= LAST;
                            busy  <= 1'b0;
                        end else begin
                            busy  <= 1'b1;
                        end
`else
                        busy    <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (count == LAST) begin
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= zero_q;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + CW'(1);
                        if (!trial[WIDTH]) begin
                            prem <= trial[WIDTH-1:0];
                            quo  <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            prem <= shifted[WIDTH-1:0];
                            quo  <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
